// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester handshakes and the shared memory port.
// slave: the arbiter's view; master: requesters plus memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 16
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ack;
    logic              r0_err;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ack;
    logic              r1_err;
    logic [DATA_W-1:0] r1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_ack, r0_err, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_ack, r1_err, r1_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_ack, r0_err, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_ack, r1_err, r1_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared data memory.
// One access per IDLE -> GRANT -> RESP pass; out-of-range requests skip GRANT.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_DEPTH = 4096
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StGrant, StResp} state_e;

    // One extra bit so a depth of exactly 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DepthLimit = (ADDR_W + 1)'(MEM_DEPTH);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

    logic              sel1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    // Pick the winner and mux its request fields.
    always_comb begin
        // Port 1 wins when alone, or on a tie when port 0 had the last grant.
        sel1         = bus.r1_req & (~bus.r0_req | ~last_grant_q);
        sel_we       = sel1 ? bus.r1_we    : bus.r0_we;
        sel_addr     = sel1 ? bus.r1_addr  : bus.r0_addr;
        sel_wdata    = sel1 ? bus.r1_wdata : bus.r0_wdata;
        sel_in_range = {1'b0, sel_addr} < DepthLimit;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
        end
    end

    // Next state: arbitrate and latch in IDLE, capture read data in GRANT.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (bus.r0_req | bus.r1_req) begin
                    port_d       = sel1;
                    last_grant_d = sel1;
                    we_d         = sel_we;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    err_d        = ~sel_in_range;
                    state_d      = sel_in_range ? StGrant : StResp;
                end
            end
            StGrant: begin
                if (!we_q) begin
                    if (port_q) r1_rdata_d = bus.mem_rdata;
                    else        r0_rdata_d = bus.mem_rdata;
                end
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: memory strobes in GRANT (gated by rst), ack/err in RESP.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.r0_ack    = 1'b0;
        bus.r0_err    = 1'b0;
        bus.r1_ack    = 1'b0;
        bus.r1_err    = 1'b0;
        unique case (state_q)
            StGrant: begin
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                bus.mem_read  = ~we_q & ~rst;
                bus.mem_write = we_q & ~rst;
            end
            StResp: begin
                bus.r0_ack = ~port_q & ~err_q;
                bus.r0_err = ~port_q & err_q;
                bus.r1_ack = port_q & ~err_q;
                bus.r1_err = port_q & err_q;
            end
            default: ;
        endcase
    end

    assign bus.r0_rdata = r0_rdata_q;
    assign bus.r1_rdata = r1_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
    localparam int AW = 13;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(4096)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared memory: writes on the edge ending the strobe cycle, comb read.
    bit [15:0]   mem [4096];
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [15:0] pre_data;
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
        if (pre_en) mem[pre_addr] <= pre_data;
    end
    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[11:0]] : 16'h0000;

    // Reference model: each accepted request schedules its future output cycles.
    typedef struct {
        bit        ack0, ack1, err0, err1, rd, wr, port;
        bit [12:0] addr;
        bit [15:0] wdata;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        blank;
    bit [15:0]   ref_mem [4096];
    logic [15:0] exp_rdata [2];
    bit          m_last;

    logic        req_v [2];
    logic        we_v [2];
    logic [12:0] addr_v [2];
    logic [15:0] wdata_v [2];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit obs_done [2];
    int ack_cnt [2];
    int err_cnt [2];
    int wr_cnt;
    int both_cnt;
    logic [15:0] last_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [12:0] a,
                            input logic [15:0] d);
        req_v[p] = r; we_v[p] = w; addr_v[p] = a; wdata_v[p] = d;
        if (p == 0) begin
            bus.r0_req = r; bus.r0_we = w; bus.r0_addr = a; bus.r0_wdata = d;
        end else begin
            bus.r1_req = r; bus.r1_we = w; bus.r1_addr = a; bus.r1_wdata = d;
        end
    endtask

    // Advance the model across one clock edge using the inputs seen at that edge.
    task automatic model_step();
        exp_t e;
        int   win;
        bit   was_idle;
        was_idle = (exp_q.size() == 0);
        if (rst) begin
            exp_q.delete();
            m_last = 1'b1;
            exp_rdata[0] = 16'h0000;
            exp_rdata[1] = 16'h0000;
        end else if (!was_idle) begin
            e = exp_q.pop_front();
            if (e.wr) ref_mem[e.addr[11:0]] = e.wdata;
            if (e.rd) exp_rdata[e.port] = ref_mem[e.addr[11:0]];
        end else if (req_v[0] || req_v[1]) begin
            if (req_v[0] && req_v[1]) win = m_last ? 0 : 1;
            else win = req_v[0] ? 0 : 1;
            m_last = (win == 1);
            if (addr_v[win] < 13'd4096) begin
                e = blank;
                e.rd = !we_v[win]; e.wr = we_v[win]; e.port = (win == 1);
                e.addr = addr_v[win]; e.wdata = wdata_v[win];
                exp_q.push_back(e);
                e = blank;
                if (win == 0) e.ack0 = 1'b1; else e.ack1 = 1'b1;
                exp_q.push_back(e);
            end else begin
                e = blank;
                if (win == 0) e.err0 = 1'b1; else e.err1 = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Compare every DUT output with the model for the current cycle.
    task automatic compare();
        exp_t e;
        e = (exp_q.size() > 0) ? exp_q[0] : blank;
        chk("r0_ack", bus.r0_ack, e.ack0);
        chk("r0_err", bus.r0_err, e.err0);
        chk("r1_ack", bus.r1_ack, e.ack1);
        chk("r1_err", bus.r1_err, e.err1);
        chk("mem_read", bus.mem_read, e.rd & !rst);
        chk("mem_write", bus.mem_write, e.wr & !rst);
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_wdata", bus.mem_wdata, e.wdata);
        chk("r0_rdata", bus.r0_rdata, exp_rdata[0]);
        chk("r1_rdata", bus.r1_rdata, exp_rdata[1]);
        obs_done[0] = bus.r0_ack | bus.r0_err;
        obs_done[1] = bus.r1_ack | bus.r1_err;
        if (bus.r0_ack) ack_cnt[0]++;
        if (bus.r1_ack) ack_cnt[1]++;
        if (bus.r0_err) err_cnt[0]++;
        if (bus.r1_err) err_cnt[1]++;
        if (bus.mem_write) begin wr_cnt++; last_wdata = bus.mem_wdata; end
        if (bus.r0_ack && bus.r1_ack) both_cnt++;
        cyc++;
    endtask

    task automatic tick(input bit rst_mid = 1'b0);
        @(posedge clk);
        model_step();
        if (rst_mid) begin #1; rst = 1'b1; end
        @(negedge clk);
        compare();
    endtask

    task automatic clr_counts();
        ack_cnt[0] = 0; ack_cnt[1] = 0; err_cnt[0] = 0; err_cnt[1] = 0;
        wr_cnt = 0; both_cnt = 0; last_wdata = 16'h0000;
    endtask

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d; ref_mem[a] = d;
        tick();
        pre_en = 1'b0;
    endtask

    // Issue one request, wait (bounded) for ack/err, drop req, idle one cycle.
    task automatic do_access(input int p, input logic w, input logic [12:0] a,
                             input logic [15:0] d, output int lat);
        bit seen;
        seen = 1'b0;
        lat = 0;
        set_port(p, 1'b1, w, a, d);
        for (int i = 1; i <= 8 && !seen; i++) begin
            tick();
            if (obs_done[p]) begin seen = 1'b1; lat = i; end
        end
        chk("access_done", seen, 1);
        set_port(p, 1'b0, w, a, d);
        tick();
    endtask

    task automatic rand_drive();
        logic [12:0] a;
        for (int p = 0; p < 2; p++) begin
            if (req_v[p] && obs_done[p]) set_port(p, 1'b0, we_v[p], addr_v[p], wdata_v[p]);
            if (!req_v[p] && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 9) == 0) a = 13'h1000 | 13'($urandom_range(0, 4095));
                else a = 13'($urandom_range(0, 31));
                set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, 16'($urandom));
            end
        end
        rst = ($urandom_range(0, 149) == 0);
    endtask

    int lat;
    int acks [$];
    int ack_cyc [$];

    initial begin
        rst = 1'b1;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        m_last = 1'b1;
        exp_rdata[0] = 16'h0000; exp_rdata[1] = 16'h0000;
        obs_done[0] = 1'b0; obs_done[1] = 1'b0;
        clr_counts();
        set_port(0, 1'b0, 1'b0, 13'd0, 16'd0);
        set_port(1, 1'b0, 1'b0, 13'd0, 16'd0);
        tick(); tick();
        preload(12'd2000, 16'h0123);
        preload(12'd2004, 16'h00AA);
        preload(12'd0, 16'h5A5A);
        preload(12'd7, 16'h7777);
        chk("rst_r0_rdata", bus.r0_rdata, 16'h0000);
        chk("rst_r1_rdata", bus.r1_rdata, 16'h0000);
        chk("rst_mem_read", bus.mem_read, 0);
        rst = 1'b0;
        tick();

        // Read of preloaded word 2000 by port 0 with exact cycle timing.
        set_port(0, 1'b1, 1'b0, 13'd2000, 16'd0);
        tick();
        chk("t1_mem_read_k1", bus.mem_read, 1);
        chk("t1_mem_addr_k1", bus.mem_addr, 13'd2000);
        tick();
        chk("t1_ack_k2", bus.r0_ack, 1);
        chk("t1_mem_read_k2", bus.mem_read, 0);
        set_port(0, 1'b0, 1'b0, 13'd2000, 16'd0);
        tick();
        chk("t1_rdata", bus.r0_rdata, 16'h0123);
        chk("t1_model_rdata", exp_rdata[0], 16'h0123);
        tick();
        chk("t1_rdata_held", bus.r0_rdata, 16'h0123);

        // Port 1 writes, port 0 reads back.
        clr_counts();
        do_access(1, 1'b1, 13'd5, 16'hBEEF, lat);
        chk("t2_wr_lat", lat, 2);
        chk("t2_wr_cycles", wr_cnt, 1);
        chk("t2_wdata", last_wdata, 16'hBEEF);
        do_access(0, 1'b0, 13'd5, 16'd0, lat);
        chk("t2_r0_rdata", bus.r0_rdata, 16'hBEEF);
        chk("t2_r1_rdata", bus.r1_rdata, 16'h0000);

        // Both ports requesting continuously right after reset.
        rst = 1'b1; tick(); rst = 1'b0;
        clr_counts();
        set_port(0, 1'b1, 1'b0, 13'd10, 16'd0);
        set_port(1, 1'b1, 1'b0, 13'd11, 16'd0);
        for (int i = 0; i < 20 && acks.size() < 4; i++) begin
            tick();
            if (bus.r0_ack) begin acks.push_back(0); ack_cyc.push_back(cyc); end
            if (bus.r1_ack) begin acks.push_back(1); ack_cyc.push_back(cyc); end
        end
        set_port(0, 1'b0, 1'b0, 13'd10, 16'd0);
        set_port(1, 1'b0, 1'b0, 13'd11, 16'd0);
        tick(); tick();
        chk("t3_ack_count", acks.size(), 4);
        for (int i = 0; i < acks.size(); i++) chk("t3_order", acks[i], i % 2);
        for (int i = 1; i < ack_cyc.size(); i++)
            chk("t3_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
        chk("t3_both_acks", both_cnt, 0);

        // Out-of-range write.
        clr_counts();
        do_access(0, 1'b1, 13'h1000, 16'hFFFF, lat);
        chk("t4_err_lat", lat, 1);
        chk("t4_err_cnt", err_cnt[0], 1);
        chk("t4_ack_cnt", ack_cnt[0], 0);
        chk("t4_wr_cnt", wr_cnt, 0);
        chk("t4_word0", mem[0], 16'h5A5A);

        // Reset during the GRANT cycle of a port 1 write.
        clr_counts();
        set_port(1, 1'b1, 1'b1, 13'd7, 16'h1234);
        tick(1'b1);
        chk("t5_mem_write", bus.mem_write, 0);
        chk("t5_mem_addr", bus.mem_addr, 13'd7);
        set_port(1, 1'b0, 1'b1, 13'd7, 16'h1234);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t5_no_ack", ack_cnt[1], 0);
        chk("t5_word7", mem[7], 16'h7777);
        do_access(0, 1'b0, 13'd7, 16'd0, lat);
        chk("t5_after_lat", lat, 2);
        chk("t5_after_rdata", bus.r0_rdata, 16'h7777);

        // Per-port read data isolation.
        do_access(0, 1'b0, 13'd2004, 16'd0, lat);
        do_access(1, 1'b0, 13'd2000, 16'd0, lat);
        chk("t6_r0_rdata", bus.r0_rdata, 16'h00AA);
        chk("t6_r1_rdata", bus.r1_rdata, 16'h0123);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            tick();
        end
        set_port(0, 1'b0, 1'b0, 13'd0, 16'd0);
        set_port(1, 1'b0, 1'b0, 13'd0, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared 4096 x 16-bit data memory. Requester 0 is the instruction-fetch/control path and requester 1 is the data/load-store path; both issue single-word reads or writes through a req/ack handshake. The block owns the memory's address, write-data and read/write strobe inputs, captures read data into per-port registers, and rejects addresses beyond the memory depth.

Parameters:
ADDR_W, 13, address width on requester and memory sides
DATA_W, 16, data word width
MEM_DEPTH, 4096, number of implemented words; addresses >= MEM_DEPTH are rejected

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
r0_req  input  1  port 0 request; held high until r0_ack or r0_err
r0_we  input  1  port 0 write (1) / read (0); stable while r0_req is high
r0_addr  input  ADDR_W  port 0 word address; stable while r0_req is high
r0_wdata  input  DATA_W  port 0 write data; stable while r0_req is high
r0_ack  output  1  one-cycle completion pulse
r0_err  output  1  one-cycle out-of-range pulse, replaces ack
r0_rdata  output  DATA_W  last read data for port 0, held until the next port 0 read completes
r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata  same as port 0, for port 1
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable; the memory writes on the clk edge ending the cycle
mem_rdata  input  DATA_W  memory read value, combinational from mem_addr while mem_read is high

Behaviour:
- Clock and reset: clk is the single clock. rst is synchronous, active-high, and overrides everything.
- Reset values: state IDLE; r*_ack=0; r*_err=0; r*_rdata=0; last_grant=1 (so port 0 wins the first tie); latched address/data/we=0.
- FSM states: IDLE, GRANT, RESP.
- IDLE:
  - If exactly one req is high, that port wins.
  - If both are high, the port != last_grant wins.
  - On the win, latch port id, we, addr and wdata, and update last_grant.
  - In-range address (addr < MEM_DEPTH): go to GRANT.
  - Out-of-range address: go to RESP with err_flag set; no memory access.
  - No req: stay in IDLE.
- GRANT (exactly one cycle):
  - mem_addr/mem_wdata come from the latches.
  - mem_read = !we_latched & !rst; mem_write = we_latched & !rst. The strobes are gated combinationally by rst so a reset in this cycle suppresses the write.
  - On a read, capture mem_rdata into the winner's rdata register at the end of the cycle.
  - Go to RESP.
- RESP (exactly one cycle):
  - Assert the winner's ack, or its err if err_flag is set.
  - Memory strobes low.
  - Go to IDLE.
- Memory outputs outside GRANT: mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0.
- Latency and throughput:
  - Request sampled at edge k, memory strobe during cycle k+1, ack during cycle k+2.
  - Err path: err during cycle k+1.
  - Peak throughput: one access per 3 cycles.
  - The requester deasserts or changes req after seeing ack/err. req still high in the RESP cycle is ignored because arbitration only happens in IDLE.
- Protocol violations:
  - A req dropped before ack does not abort the access; ack still pulses.
  - Changing addr/wdata mid-request has no effect, since the values were latched.
- r*_rdata is unchanged by writes, by errors and by the other port's accesses.
- Address check is an unsigned compare against MEM_DEPTH. With ADDR_W=13 and MEM_DEPTH=4096, any address with bit 12 set is out of range.
- rst during IDLE or RESP: a pending ack/err is dropped (outputs forced 0 next cycle) and no memory access occurs.

Test Plan:
- Preload word 2000 = 16'h0123; port 0 read at addr 2000 from IDLE -> mem_read=1 and mem_addr=2000 for exactly one cycle (k+1), r0_ack=1 at k+2, r0_rdata=16'h0123 and held afterwards.
- Port 1 write addr 5 data 16'hBEEF, then port 0 read addr 5 -> mem_write high exactly one cycle with mem_wdata=16'hBEEF, then r0_rdata=16'hBEEF; r1_rdata stays 0.
- After reset, r0_req and r1_req held high continuously (re-requesting after each ack) -> grant order 0,1,0,1 over four accesses; acks spaced 3 cycles apart; never both acks in one cycle.
- Port 0 write to addr 13'h1000 with data 16'hFFFF -> r0_err=1 at k+1, r0_ack never asserted, mem_write never asserted, word 0 unchanged.
- Port 1 write to addr 7 with rst asserted during the GRANT cycle -> mem_write=0 in that cycle, no r1_ack, state IDLE afterwards, word 7 unchanged.
- Port 0 read of addr 2004 (preloaded 16'h00AA), then port 1 read addr 2000 -> r0_rdata stays 16'h00AA while r1_rdata becomes 16'h0123.
